// File: rtl/branch_redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl_if
// Bundles the EX-stage branch-unit results and the redirect controller outputs.
//   Inputs to the controller : ex_valid, ex_pcsel, ex_halt, ex_brpc, stall_in
//   Outputs of the controller: pc_we, pc_next_sel, pc_target, flush_ifid,
//                              flush_idex, halted, misalign
// master : the pipeline side (branch unit / hazard unit / PC register)
// slave  : the redirect controller itself
// -----------------------------------------------------------------------------
interface branch_redirect_ctrl_if #(
    parameter int PC_W = 9
);
    logic            ex_valid;
    logic            ex_pcsel;
    logic            ex_halt;
    logic [31:0]     ex_brpc;
    logic            stall_in;
    logic            pc_we;
    logic            pc_next_sel;
    logic [PC_W-1:0] pc_target;
    logic            flush_ifid;
    logic            flush_idex;
    logic            halted;
    logic            misalign;

    modport master (
        output ex_valid, ex_pcsel, ex_halt, ex_brpc, stall_in,
        input  pc_we, pc_next_sel, pc_target, flush_ifid, flush_idex, halted, misalign
    );

    modport slave (
        input  ex_valid, ex_pcsel, ex_halt, ex_brpc, stall_in,
        output pc_we, pc_next_sel, pc_target, flush_ifid, flush_idex, halted, misalign
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
// Sequences control-flow redirects for the 5-stage core: turns the EX-stage
// branch-unit results into PC write enable / next-PC select, IF/ID and ID/EX
// flush strobes and the core halt state. All outputs are registered.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : branch_redirect_ctrl_if.slave (EX results in, PC/flush/halt out)
//   redirect_count, flush_cycles : 32-bit performance counters, present only
//                                  when BRANCH_REDIRECT_PERF_EN is defined
// Parameters:
//   PC_W      : PC width; the redirect target is truncated to these low bits
//   FLUSH_CYC : cycles the flush strobes stay high after a redirect (1..15)
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int PC_W      = 9,
    parameter int FLUSH_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_redirect_ctrl_if.slave bus
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [31:0]           redirect_count,
    output logic [31:0]           flush_cycles
`endif
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic            pc_we_r;
    logic            pc_next_sel_r;
    logic [PC_W-1:0] pc_target_r;
    logic            flush_r;
    logic            halted_r;
    logic            misalign_r;

    logic take;
    logic hlt;
    assign take = bus.ex_valid & bus.ex_pcsel & ~bus.ex_halt;
    assign hlt  = bus.ex_valid & bus.ex_halt;

    // Upper target bits are dropped by design.
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^bus.ex_brpc[31:PC_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            cnt           <= '0;
            pc_we_r       <= 1'b1;
            pc_next_sel_r <= 1'b0;
            pc_target_r   <= '0;
            flush_r       <= 1'b0;
            halted_r      <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (hlt) begin
                        state         <= HALT;
                        pc_we_r       <= 1'b0;
                        pc_next_sel_r <= 1'b0;
                        flush_r       <= 1'b1;
                        halted_r      <= 1'b1;
                        misalign_r    <= 1'b0;
                    end else if (take) begin
                        // Redirect wins over stall_in: the EX instruction is
                        // never held back by a load-use hazard sitting in ID.
                        state         <= FLUSH;
                        cnt           <= CNT_INIT;
                        pc_target_r   <= bus.ex_brpc[PC_W-1:0];
                        pc_next_sel_r <= 1'b1;
                        pc_we_r       <= 1'b1;
                        flush_r       <= 1'b1;
                        misalign_r    <= bus.ex_brpc[1] | bus.ex_brpc[0];
                    end else begin
                        pc_we_r       <= ~bus.stall_in;
                        pc_next_sel_r <= 1'b0;
                        flush_r       <= 1'b0;
                        misalign_r    <= 1'b0;
                    end
                end
                FLUSH: begin
                    // EX inputs here belong to squashed shadow instructions.
                    pc_we_r       <= 1'b1;
                    pc_next_sel_r <= 1'b0;
                    misalign_r    <= 1'b0;
                    if (cnt != 4'd0) begin
                        cnt     <= cnt - 4'd1;
                        flush_r <= 1'b1;
                    end else begin
                        state   <= RUN;
                        flush_r <= 1'b0;
                    end
                end
                default: begin
                    // HALT absorbs until reset; flushes only on the entry cycle.
                    pc_we_r       <= 1'b0;
                    pc_next_sel_r <= 1'b0;
                    flush_r       <= 1'b0;
                    halted_r      <= 1'b1;
                    misalign_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_we       = pc_we_r;
    assign bus.pc_next_sel = pc_next_sel_r;
    assign bus.pc_target   = pc_target_r;
    assign bus.flush_ifid  = flush_r;
    assign bus.flush_idex  = flush_r;
    assign bus.halted      = halted_r;
    assign bus.misalign    = misalign_r;

`ifdef BRANCH_REDIRECT_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_count <= '0;
            flush_cycles   <= '0;
        end else if (state != HALT) begin
            if (state == RUN && take && !hlt)
                redirect_count <= sat_inc(redirect_count);
            // Counts the cycle that just showed flush high (HALT entry excluded).
            if (flush_r)
                flush_cycles <= sat_inc(flush_cycles);
        end
    end
`endif
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow redirects in the 5-stage RISC-V core. It consumes the EX-stage branch-unit results (PcSel, BrPC, Halt) and drives the PC register's write enable and next-PC mux select. It also drives the IF/ID and ID/EX flush strobes and the core halt state. It sits between the branch unit / hazard unit and the PC register / pipeline registers.

Parameters:
PC_W, 9, width of the program counter; the target is truncated to these low bits.
FLUSH_CYC, 2, number of cycles the flush strobes stay high after a redirect; legal range 1..15.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX stage holds a valid (non-bubble) instruction
ex_pcsel  in  1  branch unit PcSel: branch/jal/jalr taken or halt
ex_halt  in  1  EX instruction is HALT
ex_brpc  in  32  branch unit BrPC target
stall_in  in  1  load-use stall request from hazard unit
pc_we  out  1  PC register write enable
pc_next_sel  out  1  1: PC loads pc_target; 0: PC loads PC+4
pc_target  out  PC_W  registered redirect target
flush_ifid  out  1  clear IF/ID register
flush_idex  out  1  clear ID/EX register
halted  out  1  core halted
misalign  out  1  one-cycle pulse: redirect target had nonzero bits [1:0]

Behaviour:
- One clock, reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block. This takes priority over everything, including mid-FLUSH and HALT.
- Reset values: state=RUN, cnt=0, pc_we=1, pc_next_sel=0, pc_target=0, flush_ifid=0, flush_idex=0, halted=0, misalign=0.
- All outputs are registered; a decision made at edge T is visible from T+1.
- FSM states are RUN, FLUSH and HALT.
- Define take = ex_valid & ex_pcsel & ~ex_halt, and hlt = ex_valid & ex_halt.
- RUN:
  - hlt has highest priority. Next state is HALT. pc_we=0, pc_next_sel=0, flush_ifid=1, flush_idex=1, halted=1.
  - Otherwise, on take: next state is FLUSH. pc_target=ex_brpc[PC_W-1:0], pc_next_sel=1, pc_we=1, flush_ifid=1, flush_idex=1, cnt=FLUSH_CYC-1. misalign=ex_brpc[1]|ex_brpc[0].
  - A redirect overrides stall_in in the same cycle, because the EX instruction is not stalled by a load-use hazard in ID.
  - Otherwise, on stall_in: pc_we=0, pc_next_sel=0, flushes 0.
  - Otherwise: pc_we=1, pc_next_sel=0, flushes 0.
- FLUSH:
  - ex_valid, ex_pcsel and ex_halt are ignored; they belong to shadow instructions being squashed. stall_in is also ignored.
  - Outputs: pc_next_sel=0, pc_we=1, flush_ifid=1, flush_idex=1, misalign=0.
  - While cnt!=0, decrement cnt.
  - When cnt==0, next state is RUN with flushes deasserted.
  - Net effect: the flushes are high for exactly FLUSH_CYC cycles and pc_next_sel is high for exactly 1 cycle.
  - With FLUSH_CYC=1, the block returns to RUN immediately after the entry cycle.
- HALT:
  - Absorbing until reset. pc_we=0, halted=1, pc_next_sel=0.
  - The flushes are high for the first HALT cycle only, then 0.
  - All inputs are ignored.
- Back-to-back: a take in the first RUN cycle after FLUSH is accepted normally, with no dead cycle.
- pc_target holds its value except when loaded on take.

Optional Feature:
Macro BRANCH_REDIRECT_PERF_EN.
- Defined: adds output ports redirect_count (32) and flush_cycles (32).
  - redirect_count increments on each RUN→FLUSH transition.
  - flush_cycles increments on every cycle in which flush_ifid=1.
  - Both reset to 0, saturate at 32'hFFFF_FFFF and freeze in HALT.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with ex_pcsel=1 → all outputs at reset values, pc_we=1, halted=0. Release → RUN.
- Taken branch: FLUSH_CYC=2, ex_valid=1, ex_pcsel=1, ex_brpc=32'h0000_0040 at edge T → at T+1 pc_next_sel=1, pc_target=9'h040, flush_ifid and flush_idex both 1. At T+2 pc_next_sel=0 with flushes still 1. At T+3 the flushes are 0. A take injected at T+1 is ignored.
- Stall vs redirect: stall_in=1 with no take → pc_we=0 next cycle. stall_in=1 with take → pc_we=1, pc_next_sel=1.
- Halt: ex_valid=1, ex_halt=1, ex_pcsel=1 → halted=1, pc_we=0 forever, flushes high for one cycle. A later take has no effect. rst_n=0 → returns to RUN.
- Misalign and truncation: ex_brpc=32'h0000_0A06 with PC_W=9 → pc_target=9'h006, misalign=1 for exactly one cycle.
- Perf (BRANCH_REDIRECT_PERF_EN defined): 3 redirects with FLUSH_CYC=2 → redirect_count=3, flush_cycles=6. Reset mid-FLUSH → both counters return to 0 and state returns to RUN.
